// File: rtl/tank_drive_ctrl.sv
// Per-player tank motion controller: keys to terrain-following motion per frame.
// Optional macro TANK_MOTION_ACCEL_EN enables step acceleration up to STEP_MAX.
module tank_drive_ctrl #(
    parameter int          COORD_W   = 10,
    parameter int          FUEL_W    = 8,
    parameter int          FUEL_MAX  = 50,
    parameter int          X_START   = 75,
    parameter int          Y_START   = 320,
    parameter int          X_MIN     = 0,
    parameter int          X_MAX     = 639,
    parameter int          Y_MIN     = 300,
    parameter int          Y_MAX     = 349,
    parameter int          TANK_SIZE = 32,
    parameter int          SLOPE_OFS = 7,
    parameter logic [7:0]  KEY_LEFT  = 8'h04,
    parameter logic [7:0]  KEY_RIGHT = 8'h07,
    parameter int          STEP_MAX  = 3
) (
    input  logic               frame_clk,
    input  logic               Reset_n,
    input  logic [7:0]         keycode,
    input  logic               my_turn,
    input  logic               turn_start,
    input  logic               blocked,
    input  logic [1:0]         slope_r,
    input  logic [1:0]         slope_l,
    output logic [COORD_W-1:0] tank_x,
    output logic [COORD_W-1:0] tank_y,
    output logic [COORD_W-1:0] tank_y_disp,
    output logic [COORD_W-1:0] tank_s,
    output logic [COORD_W-1:0] x_motion,
    output logic [COORD_W-1:0] y_motion,
    output logic [FUEL_W-1:0]  fuel,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_MOVE  = 2'b01,
        S_EMPTY = 2'b10
    } state_t;

    // Extra headroom so bound sums never wrap.
    localparam int EW = COORD_W + 2;

`ifdef TANK_MOTION_ACCEL_EN
    localparam int STEP_TOP = STEP_MAX;
`else
    localparam int STEP_TOP = 1;
`endif

    state_t             state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [COORD_W-1:0] disp_q, disp_d;
    logic [COORD_W-1:0] xm_q, xm_d;
    logic [COORD_W-1:0] ym_q, ym_d;
    logic [FUEL_W-1:0]  fuel_q, fuel_d;
    logic [COORD_W-1:0] step_q, step_d;
    logic [2:0]         run_q, run_d;

    logic               key_l, key_r, req;
    logic               r_fit_cur, r_fit_one;
    logic               l_fit_cur, l_fit_one;
    logic               mv_ok;
    logic [COORD_W-1:0] step_use;
    logic [EW-1:0]      x_ext, step_ext;
    logic signed [EW-1:0] y_sum, ymin_s, ymax_s;
    logic               on_slope;

    assign key_l = (keycode == KEY_LEFT);
    assign key_r = (keycode == KEY_RIGHT);
    assign req   = my_turn && !blocked && (fuel_q != '0);

    assign x_ext    = {2'b00, x_q};
    assign step_ext = {2'b00, step_q};

    assign r_fit_cur = (x_ext + EW'(TANK_SIZE) + step_ext) <= EW'(X_MAX);
    assign r_fit_one = (x_ext + EW'(TANK_SIZE) + EW'(1)) <= EW'(X_MAX);
    assign l_fit_cur = x_ext >= (EW'(X_MIN) + step_ext);
    assign l_fit_one = x_ext >= (EW'(X_MIN) + EW'(1));

    // Pick the step for this frame and the resulting X/Y motion.
    always_comb begin
        mv_ok    = 1'b0;
        step_use = '0;
        xm_d     = '0;
        ym_d     = '0;
        if (req && key_r) begin
            if (r_fit_cur) begin
                mv_ok    = 1'b1;
                step_use = step_q;
            end else if (r_fit_one) begin
                mv_ok    = 1'b1;
                step_use = COORD_W'(1);
            end
            if (mv_ok) begin
                xm_d = step_use;
                unique case (slope_r)
                    2'b01:   ym_d = step_use;
                    2'b10:   ym_d = -step_use;
                    default: ym_d = '0;
                endcase
            end
        end else if (req && key_l) begin
            if (l_fit_cur) begin
                mv_ok    = 1'b1;
                step_use = step_q;
            end else if (l_fit_one) begin
                mv_ok    = 1'b1;
                step_use = COORD_W'(1);
            end
            if (mv_ok) begin
                xm_d = -step_use;
                unique case (slope_l)
                    2'b01:   ym_d = -step_use;
                    2'b10:   ym_d = step_use;
                    default: ym_d = '0;
                endcase
            end
        end
    end

    assign ymin_s = EW'(Y_MIN);
    assign ymax_s = EW'(Y_MAX);
    assign y_sum  = $signed({2'b00, y_q})
                  + $signed({{2{ym_d[COORD_W-1]}}, ym_d});

    // Position, fuel and state updates for this frame.
    always_comb begin
        x_d = x_q + xm_d;
        if (y_sum < ymin_s) begin
            y_d = COORD_W'(Y_MIN);
        end else if (y_sum > ymax_s) begin
            y_d = COORD_W'(Y_MAX);
        end else begin
            y_d = y_sum[COORD_W-1:0];
        end

        if (turn_start) begin
            fuel_d = FUEL_W'(FUEL_MAX);
        end else if (mv_ok && fuel_q != '0) begin
            fuel_d = fuel_q - FUEL_W'(1);
        end else begin
            fuel_d = fuel_q;
        end

        if (mv_ok) begin
            state_d = (fuel_d == '0) ? S_EMPTY : S_MOVE;
        end else if (state_q == S_EMPTY && !turn_start) begin
            state_d = S_EMPTY;
        end else begin
            state_d = S_IDLE;
        end
    end

    // Display offset follows the slope on the side the tank last moved toward.
    always_comb begin
        on_slope = 1'b0;
        if (xm_q != '0) begin
            if (xm_q[COORD_W-1]) begin
                on_slope = (slope_l == 2'b01) || (slope_l == 2'b10);
            end else begin
                on_slope = (slope_r == 2'b01) || (slope_r == 2'b10);
            end
        end
        disp_d = on_slope ? (y_q + COORD_W'(SLOPE_OFS)) : y_q;
    end

    // Step grows every 8 consecutive moving frames; any idle frame resets it.
    always_comb begin
        step_d = COORD_W'(1);
        run_d  = '0;
        if (mv_ok) begin
            step_d = step_q;
            run_d  = run_q + 3'd1;
            if (run_q == 3'd7 && step_q < COORD_W'(STEP_TOP)) begin
                step_d = step_q + COORD_W'(1);
            end
        end
    end

    // All registered state, including the FSM, with synchronous reset.
    always_ff @(posedge frame_clk) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            x_q     <= COORD_W'(X_START);
            y_q     <= COORD_W'(Y_START);
            disp_q  <= COORD_W'(Y_START);
            xm_q    <= '0;
            ym_q    <= '0;
            fuel_q  <= FUEL_W'(FUEL_MAX);
            step_q  <= COORD_W'(1);
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            disp_q  <= disp_d;
            xm_q    <= xm_d;
            ym_q    <= ym_d;
            fuel_q  <= fuel_d;
            step_q  <= step_d;
            run_q   <= run_d;
        end
    end

    assign tank_x      = x_q;
    assign tank_y      = y_q;
    assign tank_y_disp = disp_q;
    assign tank_s      = COORD_W'(TANK_SIZE);
    assign x_motion    = xm_q;
    assign y_motion    = ym_q;
    assign fuel        = fuel_q;
    assign state       = state_q;

endmodule

// File: tb/tb_tank_drive_ctrl.sv
// Directed bench for tank_drive_ctrl (default build, step fixed at 1).
// Expected values are hand-derived from the motion/fuel/bound rules.
module tb_tank_drive_ctrl;

    logic       frame_clk = 1'b0;
    logic       Reset_n;
    logic [7:0] keycode;
    logic       my_turn;
    logic       turn_start;
    logic       blocked;
    logic [1:0] slope_r;
    logic [1:0] slope_l;
    logic [9:0] tank_x;
    logic [9:0] tank_y;
    logic [9:0] tank_y_disp;
    logic [9:0] tank_s;
    logic [9:0] x_motion;
    logic [9:0] y_motion;
    logic [7:0] fuel;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    tank_drive_ctrl dut (
        .frame_clk   (frame_clk),
        .Reset_n     (Reset_n),
        .keycode     (keycode),
        .my_turn     (my_turn),
        .turn_start  (turn_start),
        .blocked     (blocked),
        .slope_r     (slope_r),
        .slope_l     (slope_l),
        .tank_x      (tank_x),
        .tank_y      (tank_y),
        .tank_y_disp (tank_y_disp),
        .tank_s      (tank_s),
        .x_motion    (x_motion),
        .y_motion    (y_motion),
        .fuel        (fuel),
        .state       (state)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic frames(input int n);
        repeat (n) @(posedge frame_clk);
        #1;
    endtask

    task automatic do_reset();
        keycode    = 8'h00;
        my_turn    = 1'b0;
        turn_start = 1'b0;
        blocked    = 1'b0;
        slope_r    = 2'b00;
        slope_l    = 2'b00;
        Reset_n    = 1'b0;
        frames(2);
        Reset_n    = 1'b1;
    endtask

    initial begin
        // 1: reset state
        do_reset();
        chk("rst_x", 32'(tank_x), 75);
        chk("rst_y", 32'(tank_y), 320);
        chk("rst_disp", 32'(tank_y_disp), 320);
        chk("rst_fuel", 32'(fuel), 50);
        chk("rst_state", 32'(state), 0);
        chk("rst_xm", 32'(x_motion), 0);
        chk("rst_ym", 32'(y_motion), 0);
        chk("tank_s", 32'(tank_s), 32);

        // 2: right on flat ground, 10 frames
        my_turn = 1'b1;
        keycode = 8'h07;
        frames(10);
        chk("r10_x", 32'(tank_x), 85);
        chk("r10_y", 32'(tank_y), 320);
        chk("r10_fuel", 32'(fuel), 40);
        chk("r10_state", 32'(state), 1);
        chk("r10_xm", 32'(x_motion), 1);

        // 3: fuel exhaustion then refuel
        do_reset();
        my_turn = 1'b1;
        keycode = 8'h07;
        frames(60);
        chk("ex_x", 32'(tank_x), 125);
        chk("ex_fuel", 32'(fuel), 0);
        chk("ex_state", 32'(state), 2);
        chk("ex_xm", 32'(x_motion), 0);
        keycode    = 8'h00;
        turn_start = 1'b1;
        frames(1);
        turn_start = 1'b0;
        chk("ref_fuel", 32'(fuel), 50);
        chk("ref_state", 32'(state), 0);

        // 4: right bound (x+32+1 <= 639 -> x stops at 607), then left bound
        do_reset();
        my_turn    = 1'b1;
        keycode    = 8'h07;
        turn_start = 1'b1;
        frames(540);
        turn_start = 1'b0;
        frames(3);
        chk("rb_x", 32'(tank_x), 607);
        chk("rb_xm", 32'(x_motion), 0);
        chk("rb_fuel", 32'(fuel), 50);
        chk("rb_state", 32'(state), 0);
        keycode    = 8'h04;
        turn_start = 1'b1;
        frames(620);
        turn_start = 1'b0;
        frames(3);
        chk("lb_x", 32'(tank_x), 0);
        chk("lb_xm", 32'(x_motion), 0);
        chk("lb_fuel", 32'(fuel), 50);
        chk("lb_state", 32'(state), 0);
        chk("lb_y", 32'(tank_y), 320);

        // 5: left on slope_l=10 moves down, display offset one edge later
        do_reset();
        my_turn = 1'b1;
        keycode = 8'h04;
        slope_l = 2'b10;
        frames(5);
        chk("sl_x", 32'(tank_x), 70);
        chk("sl_y", 32'(tank_y), 325);
        chk("sl_ym", 32'(y_motion), 1);
        chk("sl_xm", 32'(x_motion), 10'h3FF);
        keycode = 8'h00;
        frames(1);
        chk("sl_disp", 32'(tank_y_disp), 332);
        chk("sl_y2", 32'(tank_y), 325);
        keycode = 8'h04;
        frames(30);
        chk("ymax_y", 32'(tank_y), 349);
        chk("ymax_x", 32'(tank_x), 40);
        chk("ymax_fuel", 32'(fuel), 15);

        // right on slope_r=10 climbs until Y_MIN
        do_reset();
        my_turn = 1'b1;
        keycode = 8'h07;
        slope_r = 2'b10;
        frames(25);
        chk("ymin_y", 32'(tank_y), 300);
        chk("ymin_x", 32'(tank_x), 100);
        chk("ymin_ym", 32'(y_motion), 10'h3FF);
        chk("ymin_fuel", 32'(fuel), 25);

        // 6: blocked / not my turn freeze motion and fuel
        do_reset();
        my_turn = 1'b1;
        keycode = 8'h07;
        frames(5);
        chk("bk0_x", 32'(tank_x), 80);
        blocked = 1'b1;
        frames(3);
        chk("bk_x", 32'(tank_x), 80);
        chk("bk_fuel", 32'(fuel), 45);
        chk("bk_xm", 32'(x_motion), 0);
        chk("bk_state", 32'(state), 0);
        blocked = 1'b0;
        my_turn = 1'b0;
        frames(3);
        chk("nt_x", 32'(tank_x), 80);
        chk("nt_fuel", 32'(fuel), 45);
        my_turn    = 1'b1;
        turn_start = 1'b1;
        frames(1);
        turn_start = 1'b0;
        chk("ts_x", 32'(tank_x), 81);
        chk("ts_fuel", 32'(fuel), 50);
        chk("ts_state", 32'(state), 1);

        // unrelated keycode gives no motion
        keycode = 8'h05;
        frames(2);
        chk("key_x", 32'(tank_x), 81);
        chk("key_fuel", 32'(fuel), 50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
